// File: rtl/port_7ffd_ctrl_if.sv
// CPU-side bus bundle for the #7FFD front end: raw Z80 strobes in, ioreq strobe out.
// Valid/ready: no handshake here; the strobes are level signals asynchronous to clk28, and ioreq is a one-cycle pulse.
interface port_7ffd_ctrl_if;
  logic [15:0] a;
  logic [7:0]  d;
  logic        iorq;
  logic        wr;
  logic        m1;
  logic        ioreq;

  modport master (output a, d, iorq, wr, m1, input ioreq);
  modport slave  (input a, d, iorq, wr, m1, output ioreq);
endinterface

// File: rtl/port_7ffd_ctrl.sv
// Z80 I/O front end: strobe synchronizers, ioreq pulse, and the 128K/512K paging register at #7FFD.
package common;
  typedef enum logic [1:0] {RAM_512 = 2'd0, RAM_128 = 2'd1, RAM_48 = 2'd2} rammode_t;
  typedef enum logic [1:0] {WR_IDLE, WR_CAPTURE, WR_APPLY, WR_WAIT_END} wr_state_t;
endpackage

module port_7ffd_ctrl #(
  parameter int SYNC_STAGES = 2
) (
  input  logic                clk28,
  input  logic                rst_n,
  port_7ffd_ctrl_if.slave     cpu_bus,
  input  common::rammode_t    rammode,
  output logic                port_wr,
  output logic [4:0]          ram_page,
  output logic                screen_page,
  output logic                rom_page,
  output logic                lock,
  output common::wr_state_t   dbg_state
);
  import common::*;

  logic [SYNC_STAGES-1:0] iorq_sync_q, wr_sync_q, m1_sync_q;
  logic io_act, io_wr;
  logic io_act_q, io_wr_q, ioreq_q, port_wr_q;
  logic cap_hit_q;
  logic [7:0] cap_d_q;
  logic [4:0] page_q;
  logic screen_q, rom_q, lock_q;
  logic [4:0] ram_page_q, ram_page_d;
  logic screen_page_q, screen_page_d, rom_page_q, rom_page_d, lock_out_q, lock_out_d;
  wr_state_t state_q, state_d;
  logic cap_en, accept;

  // Idle level of every Z80 strobe is high, so the chains reset to all ones.
  always_ff @(posedge clk28 or negedge rst_n) begin
    if (!rst_n) begin
      iorq_sync_q <= '1;
      wr_sync_q   <= '1;
      m1_sync_q   <= '1;
    end else begin
      iorq_sync_q <= {iorq_sync_q[SYNC_STAGES-2:0], cpu_bus.iorq};
      wr_sync_q   <= {wr_sync_q[SYNC_STAGES-2:0], cpu_bus.wr};
      m1_sync_q   <= {m1_sync_q[SYNC_STAGES-2:0], cpu_bus.m1};
    end
  end

  assign io_act = !iorq_sync_q[SYNC_STAGES-1] && m1_sync_q[SYNC_STAGES-1];
  assign io_wr  = io_act && !wr_sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk28 or negedge rst_n) begin
    if (!rst_n) begin
      io_act_q  <= 1'b0;
      io_wr_q   <= 1'b0;
      ioreq_q   <= 1'b0;
      port_wr_q <= 1'b0;
      state_q   <= WR_IDLE;
    end else begin
      io_act_q  <= io_act;
      io_wr_q   <= io_wr;
      ioreq_q   <= io_act && !io_act_q;
      port_wr_q <= accept;
      state_q   <= state_d;
    end
  end

  // Write path: one capture per rising io_wr, one decision, then hold off until the cycle ends.
  always_comb begin
    state_d = state_q;
    cap_en  = 1'b0;
    accept  = 1'b0;
    case (state_q)
      WR_IDLE: begin
        if (io_wr && !io_wr_q) begin
          cap_en  = 1'b1;
          state_d = WR_CAPTURE;
        end
      end
      WR_CAPTURE: begin
        accept  = cap_hit_q && !lock_q && (rammode != RAM_48);
        state_d = WR_APPLY;
      end
      WR_APPLY: state_d = WR_WAIT_END;
      WR_WAIT_END: begin
        if (!io_wr) state_d = WR_IDLE;
      end
      default: state_d = WR_IDLE;
    endcase
  end

  // Only the decode result of the address is kept; the Z80 holds A and D stable for the whole write.
  always_ff @(posedge clk28 or negedge rst_n) begin
    if (!rst_n) begin
      cap_hit_q <= 1'b0;
      cap_d_q   <= '0;
    end else if (cap_en) begin
      cap_hit_q <= !cpu_bus.a[15] && !cpu_bus.a[1];
      cap_d_q   <= cpu_bus.d;
    end
  end

  // lock_q can only be written while it is 0, which makes it sticky until reset.
  always_ff @(posedge clk28 or negedge rst_n) begin
    if (!rst_n) begin
      page_q   <= '0;
      screen_q <= 1'b0;
      rom_q    <= 1'b0;
      lock_q   <= 1'b0;
    end else if (accept) begin
      page_q[2:0] <= cap_d_q[2:0];
      page_q[4:3] <= (rammode == RAM_512) ? cap_d_q[7:6] : 2'b00;
      screen_q    <= cap_d_q[3];
      rom_q       <= cap_d_q[4];
      lock_q      <= cap_d_q[5];
    end
  end

  always_comb begin
    ram_page_d    = page_q;
    screen_page_d = screen_q;
    rom_page_d    = rom_q;
    lock_out_d    = lock_q;
    case (rammode)
      RAM_48: begin
        ram_page_d    = '0;
        screen_page_d = 1'b0;
        rom_page_d    = 1'b1;
        lock_out_d    = 1'b1;
      end
      RAM_128: ram_page_d[4:3] = 2'b00;
      default: ;
    endcase
  end

  always_ff @(posedge clk28 or negedge rst_n) begin
    if (!rst_n) begin
      ram_page_q    <= '0;
      screen_page_q <= 1'b0;
      rom_page_q    <= 1'b0;
      lock_out_q    <= 1'b0;
    end else begin
      ram_page_q    <= ram_page_d;
      screen_page_q <= screen_page_d;
      rom_page_q    <= rom_page_d;
      lock_out_q    <= lock_out_d;
    end
  end

  assign cpu_bus.ioreq = ioreq_q;
  assign port_wr       = port_wr_q;
  assign ram_page      = ram_page_q;
  assign screen_page   = screen_page_q;
  assign rom_page      = rom_page_q;
  assign lock          = lock_out_q;
  assign dbg_state     = state_q;
endmodule

// File: tb/tb_port_7ffd_ctrl.sv
// Bench for port_7ffd_ctrl: directed scenarios plus random I/O cycles against a cycle-scheduled model.
module tb_port_7ffd_ctrl;
  import common::*;

  logic clk28 = 1'b0;
  logic rst_n = 1'b0;
  rammode_t rammode = RAM_128;
  logic port_wr, screen_page, rom_page, lock;
  logic [4:0] ram_page;
  wr_state_t dbg_state;

  port_7ffd_ctrl_if cpu_bus ();

  port_7ffd_ctrl #(.SYNC_STAGES(2)) dut (
    .clk28       (clk28),
    .rst_n       (rst_n),
    .cpu_bus     (cpu_bus),
    .rammode     (rammode),
    .port_wr     (port_wr),
    .ram_page    (ram_page),
    .screen_page (screen_page),
    .rom_page    (rom_page),
    .lock        (lock),
    .dbg_state   (dbg_state)
  );

  // ---------------- clock ----------------
  always #18 clk28 = ~clk28;

  // ---------------- model state ----------------
  typedef struct {int cyc; logic [15:0] a; logic [7:0] d;} wr_t;
  wr_t wr_q[$];
  bit exp_io[int];
  int cyc = 0;
  int n_cmp = 0, n_fail = 0;
  int cnt_io = 0, cnt_pw = 0;
  logic [4:0] m_page = '0;
  logic m_scr = 0, m_rom = 0, m_lock = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  function automatic logic [7:0] exp_outputs();
    case (rammode)
      RAM_48:  return {5'd0, 1'b0, 1'b1, 1'b1};
      RAM_128: return {2'b00, m_page[2:0], m_scr, m_rom, m_lock};
      default: return {m_page, m_scr, m_rom, m_lock};
    endcase
  endfunction

  // ---------------- compare process ----------------
  initial begin
    logic [7:0] eo;
    logic ep, ei;
    wr_t w;
    forever begin
      @(posedge clk28);
      cyc++;
      #1;
      if (!rst_n) begin
        m_page = '0; m_scr = 0; m_rom = 0; m_lock = 0;
        exp_io.delete();
        wr_q.delete();
      end else begin
        eo = exp_outputs();
        ep = 1'b0;
        while (wr_q.size() > 0 && wr_q[0].cyc <= cyc) begin
          w = wr_q.pop_front();
          if (w.cyc == cyc && !w.a[15] && !w.a[1] && !m_lock && rammode != RAM_48) begin
            ep = 1'b1;
            m_page = {(rammode == RAM_512) ? w.d[7:6] : 2'b00, w.d[2:0]};
            m_scr  = w.d[3];
            m_rom  = w.d[4];
            m_lock = w.d[5];
          end
        end
        ei = exp_io.exists(cyc);
        if (ei) exp_io.delete(cyc);
        chk("ioreq", cpu_bus.ioreq, ei);
        chk("port_wr", port_wr, ep);
        chk("outputs", {ram_page, screen_page, rom_page, lock}, eo);
        if (cpu_bus.ioreq) cnt_io++;
        if (port_wr) cnt_pw++;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic idle(input int n);
    repeat (n) @(negedge clk28);
  endtask

  task automatic io_cycle(input logic [15:0] a, input logic [7:0] d, input bit is_wr,
                          input bit inta, input int len, input int gap);
    int e0;
    @(negedge clk28);
    cpu_bus.a    = a;
    cpu_bus.d    = d;
    cpu_bus.iorq = 1'b0;
    cpu_bus.wr   = !is_wr;
    cpu_bus.m1   = !inta;
    e0 = cyc + 1;
    if (!inta) begin
      exp_io[e0 + 2] = 1'b1;
      if (is_wr) wr_q.push_back('{cyc: e0 + 3, a: a, d: d});
    end
    repeat (len) @(negedge clk28);
    cpu_bus.iorq = 1'b1;
    cpu_bus.wr   = 1'b1;
    cpu_bus.m1   = 1'b1;
    idle(gap);
  endtask

  task automatic out7(input logic [15:0] a, input logic [7:0] d);
    io_cycle(a, d, 1'b1, 1'b0, 4, 16);
  endtask

  // ---------------- stimulus ----------------
  int io0, pw0;

  initial begin
    cpu_bus.a = '0; cpu_bus.d = '0;
    cpu_bus.iorq = 1'b1; cpu_bus.wr = 1'b1; cpu_bus.m1 = 1'b1;
    idle(3);
    chk("reset_outputs", {ram_page, screen_page, rom_page, lock}, 8'h00);
    chk("reset_ioreq", cpu_bus.ioreq, 1'b0);
    chk("reset_port_wr", port_wr, 1'b0);
    chk("reset_state", dbg_state, WR_IDLE);
    rst_n = 1'b1;
    idle(2);

    // RAM_128, OUT #17
    io0 = cnt_io; pw0 = cnt_pw;
    out7(16'h7FFD, 8'h17);
    chk("t1_ioreq_count", cnt_io - io0, 1);
    chk("t1_port_wr_count", cnt_pw - pw0, 1);
    chk("t1_outputs", {ram_page, screen_page, rom_page, lock}, {5'd7, 1'b0, 1'b1, 1'b0});

    // RAM_512 extended page, then mode switches
    rammode = RAM_512;
    out7(16'h7FFD, 8'hC3);
    chk("t2_page512", ram_page, 5'b11011);
    rammode = RAM_128;
    idle(1);
    chk("t2_page128", ram_page, 5'b00011);
    rammode = RAM_512;
    idle(1);
    chk("t2_page512_back", ram_page, 5'b11011);

    // lock then rejected write, then reset
    out7(16'h7FFD, 8'h20);
    io0 = cnt_io; pw0 = cnt_pw;
    out7(16'h7FFD, 8'h07);
    chk("t3_ioreq_count", cnt_io - io0, 1);
    chk("t3_port_wr_count", cnt_pw - pw0, 0);
    chk("t3_locked_outputs", {ram_page, screen_page, rom_page, lock}, {5'd0, 1'b0, 1'b0, 1'b1});
    rst_n = 1'b0;
    idle(1);
    chk("t3_reset_outputs", {ram_page, screen_page, rom_page, lock}, 8'h00);
    rst_n = 1'b1;
    idle(2);
    chk("t3_after_reset", {ram_page, screen_page, rom_page, lock}, 8'h00);

    // partial decode
    rammode = RAM_128;
    io0 = cnt_io; pw0 = cnt_pw;
    out7(16'h00FE, 8'h05);
    out7(16'hFFFD, 8'h05);
    chk("t4_miss_ioreq", cnt_io - io0, 2);
    chk("t4_miss_port_wr", cnt_pw - pw0, 0);
    chk("t4_miss_outputs", {ram_page, screen_page, rom_page, lock}, 8'h00);
    out7(16'h3FFD, 8'h11);
    chk("t4_hit_port_wr", cnt_pw - pw0, 1);
    chk("t4_hit_outputs", {ram_page, screen_page, rom_page, lock}, {5'd1, 1'b0, 1'b1, 1'b0});

    // INTA, then RAM_48
    io0 = cnt_io;
    io_cycle(16'h7FFD, 8'h07, 1'b0, 1'b1, 40, 8);
    chk("t5_inta_ioreq", cnt_io - io0, 0);
    rammode = RAM_48;
    pw0 = cnt_pw;
    out7(16'h7FFD, 8'h07);
    chk("t5_48_port_wr", cnt_pw - pw0, 0);
    chk("t5_48_outputs", {ram_page, screen_page, rom_page, lock}, {5'd0, 1'b0, 1'b1, 1'b1});
    rammode = RAM_128;
    idle(1);
    chk("t5_stored_kept", {ram_page, screen_page, rom_page, lock}, {5'd1, 1'b0, 1'b1, 1'b0});

    // reset in the middle of a write
    io0 = cnt_io; pw0 = cnt_pw;
    @(negedge clk28);
    cpu_bus.a = 16'h7FFD; cpu_bus.d = 8'h06;
    cpu_bus.iorq = 1'b0; cpu_bus.wr = 1'b0;
    idle(2);
    rst_n = 1'b0;
    idle(3);
    cpu_bus.iorq = 1'b1; cpu_bus.wr = 1'b1;
    idle(3);
    rst_n = 1'b1;
    idle(10);
    chk("t6_no_port_wr", cnt_pw - pw0, 0);
    chk("t6_no_ioreq", cnt_io - io0, 0);
    chk("t6_outputs", {ram_page, screen_page, rom_page, lock}, 8'h00);

    // long IORQ and back-to-back minimum spacing
    io0 = cnt_io; pw0 = cnt_pw;
    io_cycle(16'h7FFD, 8'h02, 1'b1, 1'b0, 20, 8);
    chk("t6_long_ioreq", cnt_io - io0, 1);
    chk("t6_long_port_wr", cnt_pw - pw0, 1);
    io0 = cnt_io; pw0 = cnt_pw;
    io_cycle(16'h7FFD, 8'h03, 1'b1, 1'b0, 4, 12);
    io_cycle(16'h7FFD, 8'h04, 1'b1, 1'b0, 4, 12);
    chk("t7_b2b_ioreq", cnt_io - io0, 2);
    chk("t7_b2b_port_wr", cnt_pw - pw0, 2);
    chk("t7_b2b_outputs", {ram_page, screen_page, rom_page, lock}, {5'd4, 1'b0, 1'b0, 1'b0});

    // random traffic
    for (int i = 0; i < 300; i++) begin
      logic [15:0] a;
      logic [7:0] d;
      if ($urandom_range(0, 7) == 0) rammode = rammode_t'($urandom_range(0, 2));
      if ($urandom_range(0, 39) == 0) begin
        rst_n = 1'b0;
        idle(2);
        rst_n = 1'b1;
        idle(1);
      end
      a = 16'($urandom_range(0, 65535));
      if ($urandom_range(0, 1) == 1) begin
        a[15] = 1'b0;
        a[1]  = 1'b0;
      end
      d = 8'($urandom_range(0, 255));
      if ($urandom_range(0, 9) != 0) d[5] = 1'b0;
      io_cycle(a, d, $urandom_range(0, 3) != 0, $urandom_range(0, 9) == 0,
               $urandom_range(3, 12), $urandom_range(4, 14));
    end

    idle(5);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #5ms;
    n_fail++;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
